fifo_sync_param: RTL and testbench

//   Parametrised single-clock FIFO: generic width and depth, selectable standard or

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_sync_param_if.sv | 31 +++
 rtl/fifo_ram_sdp.sv | 35 +++
 rtl/fifo_sync_param.sv | 108 ++++++++++
 tb/tb_fifo_sync_param.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and constant-function helpers
package fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - write/read/status bundle of the synchronous FIFO
interface fifo_sync_param_if #(
   parameter int WIDTH = 36,
   parameter int CW    = 10
);
   logic             flush;
   logic [WIDTH-1:0] wr_data;
   logic             wr_en;
   logic             full;
   logic             almost_full;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             empty;
   logic             almost_empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output flush, wr_data, wr_en, rd_en,
      input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  flush, wr_data, wr_en, rd_en,
      output full, almost_full, rd_data, rd_valid, empty, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/fifo_ram_sdp.sv
// rtl/fifo_ram_sdp.sv - simple dual-port RAM, sync write, registered read with enable
module fifo_ram_sdp #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 512,
   parameter int AW    = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Output register reset only; the array itself stays reset-free for RAM inference.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;
endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - single-clock FIFO: standard or FWFT read, count, level flags,
// sticky overflow/underflow and synchronous flush
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int WIDTH    = 36,
   parameter int DEPTH    = 512,
   parameter int FWFT     = FIFO_STD,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4
) (
   input logic               clk,
   input logic               rst_n,
   fifo_sync_param_if.slave  fifo_if
);
   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam bit IS_FWFT = (FWFT == FIFO_FWFT);

   if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("fifo_sync_param: AF_LEVEL out of range 0..DEPTH");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_ae
      $error("fifo_sync_param: AE_LEVEL out of range 0..DEPTH");
   end
   if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_depth
      $error("fifo_sync_param: DEPTH must be a power of two >= 4");
   end

   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          valid_q, valid_d;
   logic          overflow_q, overflow_d, underflow_q, underflow_d;
   logic          full, empty, wr_acc, rd_acc, ram_re, mem_has;

   // valid_q is the rd_valid pulse in standard mode and the output-register
   // occupancy in FWFT mode; both are exported on rd_valid.
   always_comb begin
      full    = (count_q == CW'(DEPTH));
      empty   = IS_FWFT ? ~valid_q : (count_q == '0);
      mem_has = (wr_ptr_q != rd_ptr_q);
      wr_acc  = fifo_if.wr_en & ~full;
      rd_acc  = fifo_if.rd_en & ~empty;
      ram_re  = IS_FWFT ? (mem_has & (~valid_q | rd_acc)) : rd_acc;
      valid_d = IS_FWFT ? (ram_re | (valid_q & ~rd_acc)) : rd_acc;
      overflow_d  = overflow_q  | (fifo_if.wr_en & full);
      underflow_d = underflow_q | (fifo_if.rd_en & empty);
      count_d = count_q;
      if (wr_acc && !rd_acc) begin
         count_d = count_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - CW'(1);
      end
      if (fifo_if.flush) begin
         wr_acc      = 1'b0;
         rd_acc      = 1'b0;
         ram_re      = 1'b0;
         valid_d     = 1'b0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
         count_d     = '0;
      end
      wr_ptr_d = fifo_if.flush ? '0 : wr_ptr_q + (AW+1)'(wr_acc);
      rd_ptr_d = fifo_if.flush ? '0 : rd_ptr_q + (AW+1)'(ram_re);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_ram_sdp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (wr_acc),
      .wr_addr_i (wr_ptr_q[AW-1:0]),
      .wr_data_i (fifo_if.wr_data),
      .rd_en_i   (ram_re),
      .rd_addr_i (rd_ptr_q[AW-1:0]),
      .rd_data_o (fifo_if.rd_data)
   );

   assign fifo_if.full         = full;
   assign fifo_if.empty        = empty;
   assign fifo_if.almost_full  = (count_q >= CW'(AF_LEVEL));
   assign fifo_if.almost_empty = (count_q <= CW'(AE_LEVEL));
   assign fifo_if.count        = count_q;
   assign fifo_if.rd_valid     = valid_q;
   assign fifo_if.overflow     = overflow_q;
   assign fifo_if.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed vector bench for standard and FWFT FIFO instances
module tb_fifo_sync_param;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_fail;

   fifo_sync_param_if #(.WIDTH(36), .CW(5)) s_if ();
   fifo_sync_param_if #(.WIDTH(36), .CW(5)) f_if ();

   fifo_sync_param #(.WIDTH(36), .DEPTH(16), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(2)) u_std (
      .clk     (clk),
      .rst_n   (rst_n),
      .fifo_if (s_if.slave)
   );

   fifo_sync_param #(.WIDTH(36), .DEPTH(16), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(2)) u_fw (
      .clk     (clk),
      .rst_n   (rst_n),
      .fifo_if (f_if.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr, rd, fl;
      logic [35:0] d;
      logic [4:0]  e_cnt;
      logic        e_full, e_empty, e_af, e_ae, e_rv, e_ovf, e_unf;
      logic [35:0] e_rdata;
   } vec_t;

   vec_t tbl [35];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic s_step(input logic wr, input logic rd, input logic fl, input logic [35:0] d);
      s_if.wr_en = wr; s_if.rd_en = rd; s_if.flush = fl; s_if.wr_data = d;
      @(posedge clk); #1;
   endtask

   task automatic f_step(input logic wr, input logic rd, input logic fl, input logic [35:0] d);
      f_if.wr_en = wr; f_if.rd_en = rd; f_if.flush = fl; f_if.wr_data = d;
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " s.count"}, 64'(s_if.count), 0);
      chk({tag, " s.empty"}, 64'(s_if.empty), 1);
      chk({tag, " s.full"}, 64'(s_if.full), 0);
      chk({tag, " s.ae"}, 64'(s_if.almost_empty), 1);
      chk({tag, " s.af"}, 64'(s_if.almost_full), 0);
      chk({tag, " s.rd_data"}, 64'(s_if.rd_data), 0);
      chk({tag, " s.rd_valid"}, 64'(s_if.rd_valid), 0);
      chk({tag, " s.ovf"}, 64'(s_if.overflow), 0);
      chk({tag, " s.unf"}, 64'(s_if.underflow), 0);
      chk({tag, " f.count"}, 64'(f_if.count), 0);
      chk({tag, " f.empty"}, 64'(f_if.empty), 1);
      chk({tag, " f.rd_data"}, 64'(f_if.rd_data), 0);
   endtask

   initial begin
      n_vec = 0; n_fail = 0;
      clk = 0; rst_n = 0;
      s_if.wr_en = 0; s_if.rd_en = 0; s_if.flush = 0; s_if.wr_data = '0;
      f_if.wr_en = 0; f_if.rd_en = 0; f_if.flush = 0; f_if.wr_data = '0;

      // Fill 16, overflow on 17th, drain 16 in order, then one underflow and an idle.
      for (int i = 1; i <= 16; i++) begin
         tbl[i-1] = '{wr:1, rd:0, fl:0, d:36'(i), e_cnt:5'(i), e_full:(i == 16), e_empty:0,
                      e_af:(i >= 12), e_ae:(i <= 2), e_rv:0, e_ovf:0, e_unf:0, e_rdata:0};
      end
      tbl[16] = '{wr:1, rd:0, fl:0, d:36'hBAD, e_cnt:16, e_full:1, e_empty:0,
                  e_af:1, e_ae:0, e_rv:0, e_ovf:1, e_unf:0, e_rdata:0};
      for (int j = 1; j <= 16; j++) begin
         tbl[16+j] = '{wr:0, rd:1, fl:0, d:0, e_cnt:5'(16-j), e_full:0, e_empty:(j == 16),
                       e_af:((16-j) >= 12), e_ae:((16-j) <= 2), e_rv:1, e_ovf:1, e_unf:0,
                       e_rdata:36'(j)};
      end
      tbl[33] = '{wr:0, rd:1, fl:0, d:0, e_cnt:0, e_full:0, e_empty:1,
                  e_af:0, e_ae:1, e_rv:0, e_ovf:1, e_unf:1, e_rdata:36'h10};
      tbl[34] = '{wr:0, rd:0, fl:0, d:0, e_cnt:0, e_full:0, e_empty:1,
                  e_af:0, e_ae:1, e_rv:0, e_ovf:1, e_unf:1, e_rdata:36'h10};

      #12;
      chk_reset_state("reset");
      @(negedge clk); rst_n = 1;

      for (int k = 0; k < 35; k++) begin
         s_step(tbl[k].wr, tbl[k].rd, tbl[k].fl, tbl[k].d);
         chk($sformatf("tbl[%0d].count", k), 64'(s_if.count), 64'(tbl[k].e_cnt));
         chk($sformatf("tbl[%0d].full", k), 64'(s_if.full), 64'(tbl[k].e_full));
         chk($sformatf("tbl[%0d].empty", k), 64'(s_if.empty), 64'(tbl[k].e_empty));
         chk($sformatf("tbl[%0d].af", k), 64'(s_if.almost_full), 64'(tbl[k].e_af));
         chk($sformatf("tbl[%0d].ae", k), 64'(s_if.almost_empty), 64'(tbl[k].e_ae));
         chk($sformatf("tbl[%0d].rd_valid", k), 64'(s_if.rd_valid), 64'(tbl[k].e_rv));
         chk($sformatf("tbl[%0d].rd_data", k), 64'(s_if.rd_data), 64'(tbl[k].e_rdata));
         chk($sformatf("tbl[%0d].ovf", k), 64'(s_if.overflow), 64'(tbl[k].e_ovf));
         chk($sformatf("tbl[%0d].unf", k), 64'(s_if.underflow), 64'(tbl[k].e_unf));
      end

      // Wrap: hold count at 5 with simultaneous read/write across pointer wrap.
      s_step(0, 0, 1, 0);
      chk("flush0.count", 64'(s_if.count), 0);
      chk("flush0.ovf", 64'(s_if.overflow), 0);
      chk("flush0.unf", 64'(s_if.underflow), 0);
      for (int k = 0; k < 5; k++) s_step(1, 0, 0, 36'(100 + k));
      chk("wrap.pre_count", 64'(s_if.count), 5);
      for (int k = 0; k < 40; k++) begin
         s_step(1, 1, 0, 36'(105 + k));
         chk($sformatf("wrap[%0d].count", k), 64'(s_if.count), 5);
         chk($sformatf("wrap[%0d].rd_valid", k), 64'(s_if.rd_valid), 1);
         chk($sformatf("wrap[%0d].rd_data", k), 64'(s_if.rd_data), 64'(100 + k));
      end
      chk("wrap.ovf", 64'(s_if.overflow), 0);
      chk("wrap.unf", 64'(s_if.underflow), 0);

      // Flush at count 9 with overflow set and a concurrent write.
      for (int k = 0; k < 11; k++) s_step(1, 0, 0, 36'(200 + k));
      chk("fl.full", 64'(s_if.full), 1);
      s_step(1, 0, 0, 36'hBAD);
      for (int k = 0; k < 7; k++) s_step(0, 1, 0, 0);
      chk("fl.pre_count", 64'(s_if.count), 9);
      chk("fl.pre_ovf", 64'(s_if.overflow), 1);
      s_step(1, 0, 1, 36'h777);
      chk("fl.count", 64'(s_if.count), 0);
      chk("fl.empty", 64'(s_if.empty), 1);
      chk("fl.full", 64'(s_if.full), 0);
      chk("fl.ovf", 64'(s_if.overflow), 0);
      chk("fl.unf", 64'(s_if.underflow), 0);
      chk("fl.rd_valid", 64'(s_if.rd_valid), 0);
      s_step(1, 0, 0, 36'h55);
      chk("fl.new_count", 64'(s_if.count), 1);
      s_step(0, 1, 0, 0);
      chk("fl.new_rv", 64'(s_if.rd_valid), 1);
      chk("fl.new_data", 64'(s_if.rd_data), 36'h55);
      chk("fl.new_empty", 64'(s_if.empty), 1);
      s_step(0, 1, 0, 0);
      chk("fl.after_unf", 64'(s_if.underflow), 1);
      chk("fl.after_rv", 64'(s_if.rd_valid), 0);
      chk("fl.after_data", 64'(s_if.rd_data), 36'h55);
      s_step(0, 0, 1, 0);
      s_step(0, 0, 0, 0);

      // FWFT: write into empty shows two edges later; pop empties it.
      f_step(1, 0, 0, 36'hA5);
      chk("fw1.empty", 64'(f_if.empty), 1);
      chk("fw1.count", 64'(f_if.count), 1);
      f_step(0, 0, 0, 0);
      chk("fw2.empty", 64'(f_if.empty), 0);
      chk("fw2.rd_valid", 64'(f_if.rd_valid), 1);
      chk("fw2.rd_data", 64'(f_if.rd_data), 36'hA5);
      f_step(0, 1, 0, 0);
      chk("fw3.empty", 64'(f_if.empty), 1);
      chk("fw3.count", 64'(f_if.count), 0);

      // FWFT capacity is exactly 16 including the output register.
      for (int k = 0; k < 16; k++) f_step(1, 0, 0, 36'(12'h200 + k));
      chk("fwcap.count", 64'(f_if.count), 16);
      chk("fwcap.full", 64'(f_if.full), 1);
      chk("fwcap.head", 64'(f_if.rd_data), 36'h200);
      f_step(1, 0, 0, 36'hBAD);
      chk("fwcap.ovf", 64'(f_if.overflow), 1);
      chk("fwcap.count17", 64'(f_if.count), 16);
      for (int k = 0; k < 16; k++) begin
         f_step(0, 1, 0, 0);
         chk($sformatf("fwpop[%0d].count", k), 64'(f_if.count), 64'(15 - k));
         chk($sformatf("fwpop[%0d].empty", k), 64'(f_if.empty), 64'(k == 15));
         if (k < 15) chk($sformatf("fwpop[%0d].head", k), 64'(f_if.rd_data), 64'(12'h201 + k));
      end
      f_step(0, 0, 0, 0);

      // Asynchronous reset mid-burst, checked before the next edge.
      for (int k = 0; k < 7; k++) s_step(1, 0, 0, 36'(300 + k));
      s_step(0, 1, 0, 0);
      s_step(1, 0, 0, 36'(307));
      chk("burst.count", 64'(s_if.count), 7);
      chk("burst.rd_data", 64'(s_if.rd_data), 300);
      #2 rst_n = 0;
      #1;
      chk_reset_state("midrst");
      s_if.wr_en = 0;
      #10;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
